// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous FIFO (rclk domain): Gray write-pointer synchroniser,
// read pointers, registered empty/fill/underflow. Optional almost_empty under FIFO_ALMOST_EMPTY_EN.
module fifo_read_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rclk_en,
    input  logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   rfill,
    output logic                  underflow
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    output logic                  almost_empty
`endif
);

    if (SYNC_STAGES < 2 || AEMPTY_THRESH < 0) begin : g_param_check
        $error("fifo_read_ctrl: SYNC_STAGES must be >= 2 and AEMPTY_THRESH >= 0");
    end

    logic [ADDR_WIDTH:0] sync_reg [SYNC_STAGES];
    logic [ADDR_WIDTH:0] wq_gray;
    logic [ADDR_WIDTH:0] wq_bin;

    logic [ADDR_WIDTH:0] rbin_reg;
    logic [ADDR_WIDTH:0] rbin_next;
    logic [ADDR_WIDTH:0] rgray_reg;
    logic [ADDR_WIDTH:0] rgray_next;
    logic                empty_reg;
    logic                empty_next;
    logic [ADDR_WIDTH:0] rfill_reg;
    logic [ADDR_WIDTH:0] rfill_next;
    logic                underflow_reg;
    logic                ren;

    // Plain flop chain: nothing combinational may sit between stages.
    genvar gi;
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n) sync_reg[gi] <= '0;
                else         sync_reg[gi] <= wptr_gray;
            end
        end else begin : g_rest
            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n) sync_reg[gi] <= '0;
                else         sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    assign wq_gray = sync_reg[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_g2b
        assign wq_bin[gi] = ^(wq_gray >> gi);
    end

    assign ren        = rclk_en & ~empty_reg;
    assign rbin_next  = rbin_reg + {{ADDR_WIDTH{1'b0}}, ren};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign empty_next = (rgray_next == wq_gray);
    assign rfill_next = wq_bin - rbin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_reg      <= '0;
            rgray_reg     <= '0;
            empty_reg     <= 1'b1;
            rfill_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            rbin_reg      <= rbin_next;
            rgray_reg     <= rgray_next;
            empty_reg     <= empty_next;
            rfill_reg     <= rfill_next;
            underflow_reg <= rclk_en & empty_reg;
        end
    end

`ifdef FIFO_ALMOST_EMPTY_EN
    logic almost_empty_reg;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) almost_empty_reg <= 1'b1;
        else         almost_empty_reg <= (rfill_next <= (ADDR_WIDTH+1)'(AEMPTY_THRESH));
    end

    assign almost_empty = almost_empty_reg;
`endif

    assign raddr     = rbin_reg[ADDR_WIDTH-1:0];
    assign rptr_gray = rgray_reg;
    assign empty     = empty_reg;
    assign rfill     = rfill_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: reset, sync latency, reads, underflow, wrap,
// simultaneous read/write visibility, async reset mid-drain, optional almost_empty.
module tb_fifo_read_ctrl;

    logic       rclk;
    logic       rrst_n;
    logic       rclk_en;
    logic [4:0] wptr_gray;
    logic [3:0] raddr;
    logic [4:0] rptr_gray;
    logic       empty;
    logic [4:0] rfill;
    logic       underflow;
`ifdef FIFO_ALMOST_EMPTY_EN
    logic       almost_empty;
`endif

    int checks = 0;
    int errors = 0;

    fifo_read_ctrl #(
        .ADDR_WIDTH   (4),
        .SYNC_STAGES  (2),
        .AEMPTY_THRESH(2)
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .rclk_en     (rclk_en),
        .wptr_gray   (wptr_gray),
        .raddr       (raddr),
        .rptr_gray   (rptr_gray),
        .empty       (empty),
        .rfill       (rfill),
        .underflow   (underflow)
`ifdef FIFO_ALMOST_EMPTY_EN
        ,
        .almost_empty(almost_empty)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst_n    = 1'b0;
        rclk_en   = 1'b0;
        wptr_gray = 5'b00000;
        tick();
        tick();
        rrst_n = 1'b1;
    endtask

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++;
        if (raddr !== 4'd0) begin errors++; $display("FAIL reset_raddr: got %0d want 0", raddr); end
        checks++;
        if (rptr_gray !== 5'b00000) begin errors++; $display("FAIL reset_rptr_gray: got %b want 00000", rptr_gray); end
        checks++;
        if (rfill !== 5'd0) begin errors++; $display("FAIL reset_rfill: got %0d want 0", rfill); end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", underflow); end
`ifdef FIFO_ALMOST_EMPTY_EN
        checks++;
        if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
`endif
        $display("reset: empty=%b raddr=%0d rptr_gray=%b rfill=%0d", empty, raddr, rptr_gray, rfill);
    endtask

    task automatic test_fill_latency();
        wptr_gray = 5'b00001;
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++;
            if (empty !== (e < 3)) begin
                errors++;
                $display("FAIL sync_latency_edge%0d: empty got %b want %b", e, empty, (e < 3));
            end
        end
        checks++;
        if (rfill !== 5'd1) begin errors++; $display("FAIL fill_one_rfill: got %0d want 1", rfill); end
        rclk_en = 1'b1;
        tick();
        checks++;
        if (raddr !== 4'd1) begin errors++; $display("FAIL read_one_raddr: got %0d want 1", raddr); end
        checks++;
        if (rptr_gray !== 5'b00001) begin errors++; $display("FAIL read_one_rptr_gray: got %b want 00001", rptr_gray); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL read_one_empty: got %b want 1", empty); end
        checks++;
        if (rfill !== 5'd0) begin errors++; $display("FAIL read_one_rfill: got %0d want 0", rfill); end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL read_one_underflow: got %b want 0", underflow); end
        $display("fill_one: raddr=%0d rptr_gray=%b empty=%b rfill=%0d", raddr, rptr_gray, empty, rfill);
    endtask

    task automatic test_underflow();
        rclk_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse%0d: got %b want 1", c, underflow); end
            checks++;
            if (raddr !== 4'd1 || rptr_gray !== 5'b00001 || rfill !== 5'd0) begin
                errors++;
                $display("FAIL underflow_hold%0d: raddr=%0d rptr_gray=%b rfill=%0d want 1/00001/0", c, raddr, rptr_gray, rfill);
            end
            $display("underflow cycle %0d: underflow=%b raddr=%0d", c, underflow, raddr);
        end
        rclk_en = 1'b0;
        tick();
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b want 0", underflow); end
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        do_reset();
        wptr_gray = 5'b11000;
        rclk_en   = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (empty !== 1'b0 || rfill !== 5'd16) begin
            errors++;
            $display("FAIL wrap_full_seen: empty=%b rfill=%0d want 0/16", empty, rfill);
        end
        prev = rptr_gray;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (raddr !== k[3:0] || rptr_gray !== gray(k) || rfill !== 5'(16 - k) || empty !== (k == 16)) begin
                errors++;
                $display("FAIL wrap_read%0d: raddr=%0d rptr_gray=%b rfill=%0d empty=%b want %0d/%b/%0d/%b",
                         k, raddr, rptr_gray, rfill, empty, k % 16, gray(k), 16 - k, (k == 16));
            end
            checks++;
            if ($countones(prev ^ rptr_gray) != 1) begin
                errors++;
                $display("FAIL wrap_gray_step%0d: prev=%b now=%b want one bit change", k, prev, rptr_gray);
            end
            prev = rptr_gray;
            $display("wrap read %0d: raddr=%0d rptr_gray=%b rfill=%0d empty=%b", k, raddr, rptr_gray, rfill, empty);
        end
        tick();
        checks++;
        if (raddr !== 4'd0 || rptr_gray !== 5'b11000 || empty !== 1'b1 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap_no_extra: raddr=%0d rptr_gray=%b empty=%b underflow=%b want 0/11000/1/1",
                     raddr, rptr_gray, empty, underflow);
        end
        rclk_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        wptr_gray = 5'b00001;
        tick();
        tick();
        tick();
        // Second write becomes visible on the same edge that consumes the only entry.
        wptr_gray = 5'b00011;
        tick();
        rclk_en = 1'b1;
        tick();
        rclk_en = 1'b0;
        checks++;
        if (raddr !== 4'd1 || empty !== 1'b1 || rfill !== 5'd0) begin
            errors++;
            $display("FAIL simul_read: raddr=%0d empty=%b rfill=%0d want 1/1/0", raddr, empty, rfill);
        end
        tick();
        checks++;
        if (raddr !== 4'd1 || empty !== 1'b0 || rfill !== 5'd1) begin
            errors++;
            $display("FAIL simul_new_visible: raddr=%0d empty=%b rfill=%0d want 1/0/1", raddr, empty, rfill);
        end
        rclk_en = 1'b1;
        tick();
        rclk_en = 1'b0;
        checks++;
        if (raddr !== 4'd2 || rptr_gray !== 5'b00011 || empty !== 1'b1 || rfill !== 5'd0) begin
            errors++;
            $display("FAIL simul_second_read: raddr=%0d rptr_gray=%b empty=%b rfill=%0d want 2/00011/1/0",
                     raddr, rptr_gray, empty, rfill);
        end
        $display("simultaneous: raddr=%0d rptr_gray=%b empty=%b rfill=%0d", raddr, rptr_gray, empty, rfill);
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        wptr_gray = gray(4);
        tick();
        tick();
        tick();
        rclk_en = 1'b1;
        tick();
        tick();
        checks++;
        if (raddr !== 4'd2 || rfill !== 5'd2) begin
            errors++;
            $display("FAIL drain_progress: raddr=%0d rfill=%0d want 2/2", raddr, rfill);
        end
        #2;
        rrst_n    = 1'b0;
        wptr_gray = 5'b00000;
        #1;
        checks++;
        if (raddr !== 4'd0 || rptr_gray !== 5'b00000 || empty !== 1'b1 || rfill !== 5'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: raddr=%0d rptr_gray=%b empty=%b rfill=%0d underflow=%b want 0/00000/1/0/0",
                     raddr, rptr_gray, empty, rfill, underflow);
        end
        $display("async reset mid-drain: raddr=%0d rptr_gray=%b empty=%b", raddr, rptr_gray, empty);
        rclk_en = 1'b0;
        tick();
        rrst_n = 1'b1;
    endtask

`ifdef FIFO_ALMOST_EMPTY_EN
    task automatic test_almost_empty();
        do_reset();
        wptr_gray = gray(5);
        tick();
        tick();
        tick();
        checks++;
        if (rfill !== 5'd5 || almost_empty !== 1'b0) begin
            errors++;
            $display("FAIL ae_fill5: rfill=%0d almost_empty=%b want 5/0", rfill, almost_empty);
        end
        rclk_en = 1'b1;
        for (int f = 4; f >= 0; f--) begin
            tick();
            checks++;
            if (rfill !== 5'(f) || almost_empty !== (f <= 2)) begin
                errors++;
                $display("FAIL ae_drain%0d: rfill=%0d almost_empty=%b want %0d/%b", f, rfill, almost_empty, f, (f <= 2));
            end
            $display("almost_empty drain: rfill=%0d almost_empty=%b", rfill, almost_empty);
        end
        rclk_en = 1'b0;
    endtask
`endif

    initial begin
        rrst_n    = 1'b0;
        rclk_en   = 1'b0;
        wptr_gray = 5'b00000;
        test_reset();
        test_fill_latency();
        test_underflow();
        test_wrap();
        test_simultaneous();
        test_reset_mid_drain();
`ifdef FIFO_ALMOST_EMPTY_EN
        test_almost_empty();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, want finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side controller for the asynchronous FIFO, in the rclk domain, paired with the write-side memory/enable logic.
- Synchronises the write pointer (Gray) into rclk.
- Owns the binary and Gray read pointers, drives the read address to the register bank, and generates registered empty, fill count and underflow indications.
- Exports the Gray read pointer for synchronisation back into the wclk domain to produce full.

Parameters:
ADDR_WIDTH, 4, memory address width (depth = 2**ADDR_WIDTH = 16)
SYNC_STAGES, 2, flop stages in the wptr_gray synchroniser (minimum 2)
AEMPTY_THRESH, 2, almost-empty threshold in entries (used only with FIFO_ALMOST_EMPTY_EN)

Ports:
rclk  input  1  read clock, single clock for this block
rrst_n  input  1  reset, asynchronous, active-low
rclk_en  input  1  read request; one entry consumed per cycle when accepted
wptr_gray  input  ADDR_WIDTH+1  write pointer, Gray coded, from wclk domain (asynchronous)
raddr  output  ADDR_WIDTH  read address to register bank (data_out valid combinationally while empty=0)
rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, to wclk-domain synchroniser
empty  output  1  registered FIFO-empty flag
rfill  output  ADDR_WIDTH+1  registered entry count as seen from rclk domain, 0..16
underflow  output  1  one-cycle pulse: read requested while empty

Behaviour:
- Reset (rrst_n=0, async):
  - Internal state cleared: rbin, rptr_gray and all synchroniser flops go to 0.
  - Outputs: raddr=0, rptr_gray=0, empty=1, rfill=0, underflow=0.
  - Release is synchronous to rclk.
- Accept: ren = rclk_en & ~empty. Only ren advances pointers; rclk_en while empty has no pointer effect.
- Pointers:
  - rbin is ADDR_WIDTH+1 bits; rbin_next = rbin + ren (mod 32).
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
  - rbin and rptr_gray register on rclk.
  - raddr = rbin[ADDR_WIDTH-1:0]; it is registered state, with no combinational path from rclk_en.
- Synchroniser: wptr_gray passes through SYNC_STAGES flops to give wq_gray. No logic between stages. wq_bin = Gray-to-binary(wq_gray).
- Empty: empty <= (rgray_next == wq_gray).
  - When the last entry is read, empty asserts on that same edge, so back-to-back reads never underflow.
  - Deassert latency: empty falls on the (SYNC_STAGES+1)th rclk edge after wptr_gray changes (3 edges at default). Empty is pessimistic only and must never deassert early.
- Fill: rfill <= wq_bin - rbin_next (mod 32). It is 0 whenever empty=1 and 16 when 16 entries are pending.
- Underflow: underflow <= rclk_en & empty. Single-cycle pulse per offending cycle, not sticky.
- Wrap-around:
  - After 16 accepted reads, raddr returns to 0 and rbin[ADDR_WIDTH] toggles.
  - The Gray MSB pair differing is what lets the write side tell full from empty.
  - rptr_gray changes exactly one bit per accepted read.
- Simultaneous events:
  - Read of the last entry in the same cycle a new wq_gray arrives: empty computes from rgray_next against the updated wq_gray. Result is empty=0 if the new write is visible, otherwise 1.
  - No entry is lost or read twice.
- Reset mid-operation: the async clear abandons any in-flight read; the block returns to reset values immediately. The system resets the write side concurrently (FIFO flush); this block does not resynchronise partial state.
- rptr_gray is driven straight from a flop, with no combinational logic before the crossing.

Optional Feature:
Macro FIFO_ALMOST_EMPTY_EN.
- Defined:
  - Adds output almost_empty (1 bit), registered: almost_empty <= (rfill_next <= AEMPTY_THRESH).
  - rfill_next is the value being loaded into rfill.
  - Reset value 1. Same timing as empty.
- Undefined: the port and its logic are absent. AEMPTY_THRESH is unused.

Test Plan:
- Reset with wptr_gray=00000: empty=1, raddr=0, rptr_gray=00000, rfill=0. Assert rrst_n low mid-drain -> all outputs return to reset values without waiting for an rclk edge.
- Drive wptr_gray 00000->00001 with rclk_en=0: empty falls on the 3rd rclk edge, rfill=1. One read -> raddr=1, rptr_gray=00001, empty=1 on that edge.
- Write pointer to 16 (binary 10000, Gray 11000) with rclk_en held high: exactly 16 reads accepted and rfill counts 16 down to 0. raddr wraps 15->0, rptr_gray ends 11000, empty=1; no extra pointer advance.
- rclk_en=1 while empty: underflow pulses 1 each cycle; raddr, rptr_gray and rfill unchanged.
- Last entry read in the same cycle wq_gray advances by one: empty=0 next cycle, rfill=1, data at the new raddr readable.
- With FIFO_ALMOST_EMPTY_EN and AEMPTY_THRESH=2, fill 5 then drain: almost_empty=0 at rfill 5..3, and 1 at rfill 2, 1 and 0.
